display_sprite_writer: RTL and testbench
========================================

// Module: display_sprite_writer
// PURPOSE
// Writer end of the CHIP-8 framebuffer that the video path reads. Executes CLS and DRW commands from a
// processor by read-modify-writing the 256-byte monochrome framebuffer, and reports the VF collision flag.
// Framebuffer layout: byte address = {y[4:0], x[5:3]}; bit 7 of each byte is the leftmost pixel.
// Sits between the processor core (command side), the CHIP-8 RAM (sprite source) and framebuffer port B.
// PARAMETERS
// WRAP         0  1: sprite pixels past the right/bottom edge wrap to column/row 0; 0: they are clipped
// MEM_LATENCY  2  cycles from mem_addr_out to valid mem_data_in (BRAM read)
// FB_LATENCY   2  cycles from fb_addr_out (fb_we_out=0) to valid fb_data_in
// PORTS
// clk_in         in   1   clock
// rst_in         in   1   synchronous active-high reset
// cls_valid_in   in   1   clear-screen request; accepted when ready_out=1
// draw_valid_in  in   1   draw-sprite request; accepted when ready_out=1
// x_in           in   8   sprite x (VX); only x_in[5:0] used (start wraps mod 64)
// y_in           in   8   sprite y (VY); only y_in[4:0] used (start wraps mod 32)
// n_in           in   4   sprite height in rows (0..15)
// i_addr_in      in   12  sprite base address (I register)
// ready_out      out  1   1 when IDLE and able to accept a command
// done_out       out  1   one-cycle pulse when a command completes
// collision_out  out  1   VF result of the last DRW; valid from done_out, held until next accept
// mem_addr_out   out  12  sprite RAM read address
// mem_data_in    in   8   sprite RAM read data
// fb_addr_out    out  8   framebuffer address
// fb_we_out      out  1   framebuffer write enable
// fb_data_out    out  8   framebuffer write data
// fb_data_in     in   8   framebuffer read data
// BEHAVIOUR
// - Reset: state IDLE, ready_out=1, done_out=0, collision_out=0, fb_we_out=0, all addresses/data 0.
// - Reset mid-command aborts at once; partially written framebuffer contents are left as-is.
// - Accept: cls_valid_in|draw_valid_in while ready_out=1; operands latched that cycle, ready_out drops the next.
//   Both valid together: CLS wins, draw dropped. Requests while ready_out=0 are ignored (not queued).
// - States: IDLE, CLEAR, FETCH, WAIT_SPR, RD_L, WAIT_L, WR_L, RD_R, WAIT_R, WR_R, NEXT_ROW, DONE.
// - CLEAR: writes 8'h00 to addresses 0..255, one per cycle (256 cycles, fb_we_out=1), then DONE.
//   collision_out is left unchanged by CLS.
// - DRW: collision cleared on accept. n_in=0: straight to DONE, nothing written.
//   For row r=0..n-1: read byte at i_addr+r (12-bit wrap); sprite row s = {byte,8'h00} >> x[2:0].
//   Row y = y0+r (5-bit). If y0+r>31 and WRAP=0, the row is skipped (no fb access) and the FSM goes to NEXT_ROW.
//   Left byte addr {y, x[5:3]}: read, write old ^ s[15:8]. Right byte addr {y, x[5:3]+1} (3-bit wrap),
//   accessed only if s[7:0]!=0 and (x[5:3]!=7 or WRAP=1); write old ^ s[7:0].
//   Collision set if any (old & sprite part) != 0 on any written byte.
// - Each read waits exactly FB_LATENCY/MEM_LATENCY cycles in its WAIT state; the write follows on the next cycle.
// - DONE: done_out=1 for one cycle, then IDLE with ready_out=1 on the following cycle.
// - fb_we_out is high only in CLEAR and WR_L/WR_R; fb_data_out is don't-care-free (0 when not writing).
// TESTING
// - Reset then CLS -> exactly 256 writes of 8'h00 to addresses 0..255, one done_out pulse, ready_out returns to 1.
// - Fb cleared; RAM[0x200]=0xF0; DRW x=0,y=0,n=1,I=0x200 -> fb[0]=0xF0, fb[1] untouched, collision_out=0.
// - Repeat the same DRW -> fb[0]=0x00, collision_out=1.
// - RAM=0xFF, DRW x=4,y=0,n=1 on a clear fb -> fb[0]=0x0F, fb[1]=0xF0, collision_out=0.
// - DRW x=60,y=0,n=1, byte 0xFF: WRAP=0 -> fb[7]=0x0F, fb[0] unchanged;
//   WRAP=1 -> fb[7]=0x0F, fb[0]^=0xF0.
// - DRW y=31,n=3, WRAP=0 -> only row 31 written (addr 0xF8..). Assert rst_in mid-draw -> IDLE next cycle,
//   no further fb writes, ready_out=1, done_out never pulses.

Source files
------------

// File: rtl/display_sprite_writer.sv
// CHIP-8 framebuffer writer: executes CLS and DRW by read-modify-writing the
// 256-byte monochrome framebuffer and reports the VF collision flag.
module display_sprite_writer #(
    parameter bit WRAP        = 1'b0,
    parameter int MEM_LATENCY = 2,
    parameter int FB_LATENCY  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cls_valid_in,
    input  logic        draw_valid_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_addr_in,
    output logic        ready_out,
    output logic        done_out,
    output logic        collision_out,
    output logic [11:0] mem_addr_out,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  fb_addr_out,
    output logic        fb_we_out,
    output logic [7:0]  fb_data_out,
    input  logic [7:0]  fb_data_in
);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT_SPR, S_RD_L, S_WAIT_L,
        S_WR_L, S_RD_R, S_WAIT_R, S_WR_R, S_NEXT_ROW, S_DONE
    } state_t;

    localparam logic [3:0] MEM_LAST = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] FB_LAST  = 4'(FB_LATENCY - 1);

    state_t      state_q, state_d;
    logic [5:0]  x_q, x_d;
    logic [4:0]  y_q, y_d;
    logic [3:0]  n_q, n_d;
    logic [11:0] i_q, i_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] spr_q, spr_d;
    logic [7:0]  old_q, old_d;
    logic [7:0]  clr_q, clr_d;
    logic        coll_q, coll_d;

    logic [5:0]  row_sum;
    logic        row_off;
    logic [7:0]  addr_l;
    logic [7:0]  addr_r;
    logic [11:0] spr_addr;
    logic        need_r;
    logic        unused_bits;

    // Row index keeps a carry bit so clipping can see rows that fall below row 31.
    assign row_sum       = {1'b0, y_q} + {2'b00, row_q};
    assign row_off       = !WRAP && row_sum[5];
    assign addr_l        = {row_sum[4:0], x_q[5:3]};
    assign addr_r        = {row_sum[4:0], x_q[5:3] + 3'd1};
    assign spr_addr      = i_q + {8'h00, row_q};
    assign need_r        = (spr_q[7:0] != 8'h00) && ((x_q[5:3] != 3'd7) || WRAP);
    assign unused_bits   = ^{x_in[7:6], y_in[7:5]};
    assign collision_out = coll_q;

    // NOTE: only the control registers are reset; the framebuffer lives outside
    // this block and keeps whatever an aborted command already wrote.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            i_q     <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            spr_q   <= '0;
            old_q   <= '0;
            clr_q   <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            n_q     <= n_d;
            i_q     <= i_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            spr_q   <= spr_d;
            old_q   <= old_d;
            clr_q   <= clr_d;
            coll_q  <= coll_d;
        end
    end

    // NOTE: every output is decoded from state_q alone, so a synchronous reset
    // silences the framebuffer port on the cycle right after it is sampled.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        n_d          = n_q;
        i_d          = i_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        spr_d        = spr_q;
        old_d        = old_q;
        clr_d        = clr_q;
        coll_d       = coll_q;
        ready_out    = 1'b0;
        done_out     = 1'b0;
        mem_addr_out = '0;
        fb_addr_out  = '0;
        fb_we_out    = 1'b0;
        fb_data_out  = '0;

        case (state_q)
            S_IDLE: begin
                ready_out = 1'b1;
                if (cls_valid_in) begin
                    clr_d   = '0;
                    state_d = S_CLEAR;
                end else if (draw_valid_in) begin
                    x_d     = x_in[5:0];
                    y_d     = y_in[4:0];
                    n_d     = n_in;
                    i_d     = i_addr_in;
                    row_d   = '0;
                    coll_d  = 1'b0;
                    state_d = (n_in == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_CLEAR: begin
                fb_addr_out = clr_q;
                fb_we_out   = 1'b1;
                clr_d       = clr_q + 8'd1;
                if (clr_q == 8'hFF) state_d = S_DONE;
            end
            S_FETCH: begin
                if (row_off) begin
                    state_d = S_NEXT_ROW;
                end else begin
                    mem_addr_out = spr_addr;
                    cnt_d        = '0;
                    state_d      = S_WAIT_SPR;
                end
            end
            S_WAIT_SPR: begin
                mem_addr_out = spr_addr;
                if (cnt_q == MEM_LAST) begin
                    spr_d   = {mem_data_in, 8'h00} >> x_q[2:0];
                    state_d = S_RD_L;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_L: begin
                fb_addr_out = addr_l;
                cnt_d       = '0;
                state_d     = S_WAIT_L;
            end
            S_WAIT_L: begin
                fb_addr_out = addr_l;
                if (cnt_q == FB_LAST) begin
                    old_d   = fb_data_in;
                    state_d = S_WR_L;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_L: begin
                fb_addr_out = addr_l;
                fb_we_out   = 1'b1;
                fb_data_out = old_q ^ spr_q[15:8];
                if ((old_q & spr_q[15:8]) != 8'h00) coll_d = 1'b1;
                state_d = need_r ? S_RD_R : S_NEXT_ROW;
            end
            S_RD_R: begin
                fb_addr_out = addr_r;
                cnt_d       = '0;
                state_d     = S_WAIT_R;
            end
            S_WAIT_R: begin
                fb_addr_out = addr_r;
                if (cnt_q == FB_LAST) begin
                    old_d   = fb_data_in;
                    state_d = S_WR_R;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_R: begin
                fb_addr_out = addr_r;
                fb_we_out   = 1'b1;
                fb_data_out = old_q ^ spr_q[7:0];
                if ((old_q & spr_q[7:0]) != 8'h00) coll_d = 1'b1;
                state_d = S_NEXT_ROW;
            end
            S_NEXT_ROW: begin
                row_d   = row_q + 4'd1;
                state_d = (row_q == n_q - 4'd1) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done_out = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_display_sprite_writer.sv
// Bench for display_sprite_writer: a clipping and a wrapping instance, checked
// against a pixel-grid model of CHIP-8 CLS/DRW.
module tb_display_sprite_writer;

    localparam int LAT    = 2;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cls_v    [2];
    logic        draw_v   [2];
    logic [7:0]  x_s, y_s;
    logic [3:0]  n_s;
    logic [11:0] i_s;
    logic        ready    [2];
    logic        done     [2];
    logic        coll     [2];
    logic [11:0] mem_addr [2];
    logic [7:0]  mem_data [2];
    logic [7:0]  fb_addr  [2];
    logic        fb_we    [2];
    logic [7:0]  fb_wdata [2];
    logic [7:0]  fb_rdata [2];

    logic [7:0]  ram      [4096];
    logic [7:0]  fb       [2][256];
    logic [7:0]  mem_pipe [2][LAT];
    logic [7:0]  fb_pipe  [2][LAT];
    int          wr_cnt   [2];
    int          done_cnt [2];
    logic [15:0] wlog0 [$];
    logic [15:0] wlog1 [$];

    bit pix   [2][32][64];
    bit m_col [2];
    int checks;
    int errors;

    display_sprite_writer #(.WRAP(1'b0), .MEM_LATENCY(LAT), .FB_LATENCY(LAT)) dut_clip (
        .clk_in(clk), .rst_in(rst),
        .cls_valid_in(cls_v[0]), .draw_valid_in(draw_v[0]),
        .x_in(x_s), .y_in(y_s), .n_in(n_s), .i_addr_in(i_s),
        .ready_out(ready[0]), .done_out(done[0]), .collision_out(coll[0]),
        .mem_addr_out(mem_addr[0]), .mem_data_in(mem_data[0]),
        .fb_addr_out(fb_addr[0]), .fb_we_out(fb_we[0]),
        .fb_data_out(fb_wdata[0]), .fb_data_in(fb_rdata[0])
    );

    display_sprite_writer #(.WRAP(1'b1), .MEM_LATENCY(LAT), .FB_LATENCY(LAT)) dut_wrap (
        .clk_in(clk), .rst_in(rst),
        .cls_valid_in(cls_v[1]), .draw_valid_in(draw_v[1]),
        .x_in(x_s), .y_in(y_s), .n_in(n_s), .i_addr_in(i_s),
        .ready_out(ready[1]), .done_out(done[1]), .collision_out(coll[1]),
        .mem_addr_out(mem_addr[1]), .mem_data_in(mem_data[1]),
        .fb_addr_out(fb_addr[1]), .fb_we_out(fb_we[1]),
        .fb_data_out(fb_wdata[1]), .fb_data_in(fb_rdata[1])
    );

    // Sprite RAM and framebuffer memories with fixed read latency, plus write/done logging.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fb_we[k]) begin
                fb[k][fb_addr[k]] <= fb_wdata[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
            mem_pipe[k][0] <= ram[mem_addr[k]];
            fb_pipe[k][0]  <= fb[k][fb_addr[k]];
            for (int s = 1; s < LAT; s++) begin
                mem_pipe[k][s] <= mem_pipe[k][s-1];
                fb_pipe[k][s]  <= fb_pipe[k][s-1];
            end
        end
        if (fb_we[0]) wlog0.push_back({fb_addr[0], fb_wdata[0]});
        if (fb_we[1]) wlog1.push_back({fb_addr[1], fb_wdata[1]});
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_data[k] = mem_pipe[k][LAT-1];
            fb_rdata[k] = fb_pipe[k][LAT-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input int a);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[7-b] = pix[k][a/8][(a%8)*8 + b];
        return v;
    endfunction

    function automatic logic [15:0] get_log(input int k, input int j);
        if (k == 0) return wlog0[j];
        return wlog1[j];
    endfunction

    task automatic model_cls(input int k);
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 64; xx++) pix[k][yy][xx] = 1'b0;
    endtask

    // Pixel-level DRW: each set sprite pixel toggles one screen pixel; instance 1 wraps.
    task automatic model_draw(input int k, input logic [7:0] xx, input logic [7:0] yy,
                              input logic [3:0] nn, input logic [11:0] ii, output int writes);
        logic [7:0] b;
        int px, py, x0, y0;
        bit right, col;
        x0 = int'(xx[5:0]);
        y0 = int'(yy[4:0]);
        col = 1'b0;
        writes = 0;
        for (int r = 0; r < int'(nn); r++) begin
            b  = ram[ii + 12'(r)];
            py = y0 + r;
            if (py > 31) begin
                if (k == 0) continue;
                py -= 32;
            end
            writes++;
            right = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (b[7-c]) begin
                    px = x0 + c;
                    if (px > 63) begin
                        if (k == 0) continue;
                        px -= 64;
                    end
                    if ((x0 % 8) + c >= 8) right = 1'b1;
                    if (pix[k][py][px]) col = 1'b1;
                    pix[k][py][px] = !pix[k][py][px];
                end
            end
            if (right) writes++;
        end
        m_col[k] = col;
    endtask

    task automatic image_check(input int k);
        int nmis;
        nmis = 0;
        for (int a = 0; a < 256; a++)
            if (fb[k][a] !== exp_byte(k, a)) nmis++;
        check(k == 0 ? "fb_image_clip" : "fb_image_wrap", nmis, 0);
    endtask

    // kind: 0 = DRW, 1 = CLS, 2 = both valid. poke pulses requests while busy.
    task automatic cmd(input int k, input int kind, input logic [7:0] xx, input logic [7:0] yy,
                       input logic [3:0] nn, input logic [11:0] ii, input bit poke);
        int w0, d0, q0, exp_w, bad;
        bit seen;
        @(negedge clk);
        check("ready_before_accept", 32'(ready[k]), 1);
        w0 = wr_cnt[k];
        d0 = done_cnt[k];
        q0 = (k == 0) ? wlog0.size() : wlog1.size();
        x_s = xx; y_s = yy; n_s = nn; i_s = ii;
        cls_v[k]  = (kind != 0);
        draw_v[k] = (kind != 1);
        if (kind == 0) model_draw(k, xx, yy, nn, ii, exp_w);
        else begin
            model_cls(k);
            exp_w = 256;
        end
        @(negedge clk);
        cls_v[k]  = 1'b0;
        draw_v[k] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (done[k]) begin
                seen = 1'b1;
                break;
            end
            draw_v[k] = poke && (c == 2);
            cls_v[k]  = poke && (c == 3);
            @(negedge clk);
        end
        draw_v[k] = 1'b0;
        cls_v[k]  = 1'b0;
        check("done_seen", 32'(seen), 1);
        check(kind == 0 ? "collision" : "collision_kept_by_cls", 32'(coll[k]), 32'(m_col[k]));
        @(negedge clk);
        check("done_one_cycle", 32'(done[k]), 0);
        check("ready_after_done", 32'(ready[k]), 1);
        repeat (3) @(negedge clk);
        check("done_pulses", done_cnt[k] - d0, 1);
        check("write_count", wr_cnt[k] - w0, exp_w);
        if (kind != 0) begin
            bad = 0;
            for (int j = 0; j < 256; j++) begin
                if (q0 + j >= ((k == 0) ? wlog0.size() : wlog1.size())) bad++;
                else if (get_log(k, q0 + j) !== {8'(j), 8'h00}) bad++;
            end
            check("cls_sequence", bad, 0);
        end
        image_check(k);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, d0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cls_v[k]  = 1'b0;
            draw_v[k] = 1'b0;
            m_col[k]  = 1'b0;
        end
        x_s = '0; y_s = '0; n_s = '0; i_s = '0;
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 32'(ready[k]), 1);
            check("rst_done", 32'(done[k]), 0);
            check("rst_collision", 32'(coll[k]), 0);
            check("rst_fb_we", 32'(fb_we[k]), 0);
            check("rst_fb_addr", 32'(fb_addr[k]), 0);
            check("rst_fb_data", 32'(fb_wdata[k]), 0);
            check("rst_mem_addr", 32'(mem_addr[k]), 0);
        end
        rst = 1'b0;

        cmd(0, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
        cmd(1, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);

        ram[12'h200] = 8'hF0;
        cmd(0, 0, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0);
        check("first_draw_fb0", 32'(fb[0][0]), 32'h0F0);
        check("first_draw_fb1", 32'(fb[0][1]), 32'h000);
        check("first_draw_vf", 32'(coll[0]), 0);
        cmd(0, 0, 8'd0, 8'd0, 4'd1, 12'h200, 1'b1);
        check("redraw_fb0", 32'(fb[0][0]), 32'h000);
        check("redraw_vf", 32'(coll[0]), 1);

        cmd(0, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b1);
        ram[12'h300] = 8'hFF;
        cmd(0, 0, 8'd4, 8'd0, 4'd1, 12'h300, 1'b0);
        check("split_fb0", 32'(fb[0][0]), 32'h00F);
        check("split_fb1", 32'(fb[0][1]), 32'h0F0);
        check("split_vf", 32'(coll[0]), 0);

        cmd(0, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
        cmd(0, 0, 8'd60, 8'd0, 4'd1, 12'h300, 1'b0);
        cmd(1, 0, 8'd60, 8'd0, 4'd1, 12'h300, 1'b0);
        check("edge_clip_fb7", 32'(fb[0][7]), 32'h00F);
        check("edge_clip_fb0", 32'(fb[0][0]), 32'h000);
        check("edge_wrap_fb7", 32'(fb[1][7]), 32'h00F);
        check("edge_wrap_fb0", 32'(fb[1][0]), 32'h0F0);

        cmd(0, 0, 8'd9, 8'd9, 4'd0, 12'h300, 1'b0);
        cmd(1, 2, 8'd5, 8'd5, 4'd4, 12'h300, 1'b0);

        cmd(0, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
        ram[12'h400] = 8'hAA; ram[12'h401] = 8'hBB; ram[12'h402] = 8'hCC;
        cmd(0, 0, 8'd0, 8'd31, 4'd3, 12'h400, 1'b0);
        check("bottom_clip_row31", 32'(fb[0][8'hF8]), 32'h0AA);
        check("bottom_clip_row0", 32'(fb[0][0]), 32'h000);
        cmd(1, 0, 8'd0, 8'd31, 4'd3, 12'h400, 1'b0);
        cmd(1, 0, 8'hCA, 8'hEA, 4'd3, 12'hFFE, 1'b0);

        for (int a = 0; a < 15; a++) ram[12'h500 + 12'(a)] = 8'hFF;
        @(negedge clk);
        x_s = 8'd3; y_s = 8'd2; n_s = 4'd15; i_s = 12'h500;
        draw_v[0] = 1'b1;
        @(negedge clk);
        draw_v[0] = 1'b0;
        repeat (20) @(negedge clk);
        check("busy_mid_draw", 32'(ready[0]), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready[0]), 1);
        check("abort_fb_we", 32'(fb_we[0]), 0);
        check("abort_done", 32'(done[0]), 0);
        check("abort_collision", 32'(coll[0]), 0);
        m_col[0] = 1'b0;
        m_col[1] = 1'b0;
        w0 = wr_cnt[0];
        d0 = done_cnt[0];
        repeat (50) @(negedge clk);
        check("abort_no_writes", wr_cnt[0] - w0, 0);
        check("abort_no_done", done_cnt[0] - d0, 0);
        cmd(0, 1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);

        for (int it = 0; it < 60; it++) begin
            int sel;
            sel = int'($urandom_range(0, 15));
            cmd(it % 2, (sel == 0) ? 1 : (sel == 1) ? 2 : 0,
                8'($urandom), 8'($urandom), 4'($urandom), 12'($urandom), sel == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
